// File: rtl/vmicro16_wb_interconnect_pkg.sv
// Shared definitions for the vmicro16 Wishbone interconnect.
//   state_t  : bus ownership state (IDLE, OWNED)
//   DEF_*    : default widths and counts used by the interface and top level
//   next_rr  : round-robin pointer advance with wrap at the master count
package vmicro16_wb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_NUM_SLAVES  = 4;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_SEL_W       = 4;
  localparam int DEF_TIMEOUT     = 255;

  // Pointer to the master just after the one that released the bus.
  function automatic int unsigned next_rr(input int unsigned gnt, input int unsigned num);
    return (gnt + 1 >= num) ? 0 : gnt + 1;
  endfunction

endpackage

// File: rtl/vmicro16_wb_interconnect_if.sv
// Bundle of all master-side and slave-side Wishbone signals of the
// interconnect. Master k's address/data occupy [k*W +: W] of the packed
// vectors; slave s's read data occupies [s*DATA_W +: DATA_W].
//   modport slave  : the interconnect's view (it serves the core masters)
//   modport master : the environment's view (cores and peripherals)
interface vmicro16_wb_interconnect_if
  import vmicro16_wb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) ();

  logic [NUM_MASTERS-1:0]        m_cyc_i;
  logic [NUM_MASTERS-1:0]        m_stb_i;
  logic [NUM_MASTERS-1:0]        m_we_i;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i;
  logic [NUM_MASTERS*DATA_W-1:0] m_data_i;
  logic [DATA_W-1:0]             m_data_o;
  logic [NUM_MASTERS-1:0]        m_ack_o;
  logic [NUM_MASTERS-1:0]        m_err_o;

  logic                          s_cyc_o;
  logic [NUM_SLAVES-1:0]         s_stb_o;
  logic                          s_we_o;
  logic [ADDR_W-1:0]             s_addr_o;
  logic [DATA_W-1:0]             s_data_o;
  logic [NUM_SLAVES*DATA_W-1:0]  s_data_i;
  logic [NUM_SLAVES-1:0]         s_ack_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    output m_data_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
    input  m_data_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o
  );

endinterface

// File: rtl/vmicro16_wb_interconnect_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector, one bit per master
//   ptr : index where the search starts (searches upward, wraps)
//   gnt : index of the first requester at or after ptr
//   vld : at least one request present
module vmicro16_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt,
  output logic          vld
);

  always_comb begin
    int idx;
    gnt = '0;
    vld = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!vld && (j == idx) && req[j]) begin
          vld = 1'b1;
          gnt = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/vmicro16_wb_interconnect.sv
// Shared-bus Wishbone (classic, single transfer) interconnect for the
// vmicro16 SoC. Round-robin arbitration hands the bus to one master for the
// duration of its cyc; the granted master's signals are muxed onto the slave
// bus and the upper SEL_W address bits pick a one-hot slave strobe.
// Unmapped addresses are terminated with ack+err.
//
// Ports: clk, reset (synchronous, active-high), bus (slave modport of
// vmicro16_wb_interconnect_if carrying all m_* and s_* signals).
//
// Optional feature: define VMICRO16_WB_TIMEOUT_EN to error-terminate a
// strobe that a slave leaves unacknowledged for TIMEOUT cycles. Without it a
// silent slave stalls the bus until the master drops cyc.
module vmicro16_wb_interconnect
  import vmicro16_wb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  vmicro16_wb_interconnect_if.slave  bus
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 1 || NUM_MASTERS > 8 || NUM_SLAVES < 1 || NUM_SLAVES > 16 ||
      SEL_W < 1 || SEL_W > ADDR_W || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("vmicro16_wb_interconnect: parameter out of range");
  end

  state_t          state;
  logic [MW-1:0]   gnt;
  logic [MW-1:0]   rr;
  logic [MW-1:0]   arb_gnt;
  logic            arb_vld;

  vmicro16_rr_arbiter #(.N(NUM_MASTERS), .IW(MW)) u_arb (
    .req (bus.m_cyc_i),
    .ptr (rr),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );

  // Granted-master mux
  logic                   cyc_g, stb_g, we_g;
  logic [ADDR_W-1:0]      addr_g;
  logic [DATA_W-1:0]      data_g;
  logic [NUM_MASTERS-1:0] gnt_oh;

  always_comb begin
    cyc_g  = 1'b0;
    stb_g  = 1'b0;
    we_g   = 1'b0;
    addr_g = '0;
    data_g = '0;
    gnt_oh = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (gnt == MW'(k)) begin
        cyc_g     = bus.m_cyc_i[k];
        stb_g     = bus.m_stb_i[k];
        we_g      = bus.m_we_i[k];
        addr_g    = bus.m_addr_i[k*ADDR_W +: ADDR_W];
        data_g    = bus.m_data_i[k*DATA_W +: DATA_W];
        gnt_oh[k] = 1'b1;
      end
    end
  end

  // Everything on the slave side is qualified by the granted cyc, so the
  // cycle in which the owner drops cyc already shows an idle slave bus.
  logic              active;
  logic              stb;
  logic [ADDR_W-1:0] addr_s;
  logic [SEL_W-1:0]  sel;

  assign active       = (state == OWNED) && cyc_g;
  assign stb          = active && stb_g;
  assign addr_s       = active ? addr_g : '0;
  assign sel          = addr_s[ADDR_W-1 -: SEL_W];
  assign bus.s_cyc_o  = active;
  assign bus.s_we_o   = active && we_g;
  assign bus.s_addr_o = addr_s;
  assign bus.s_data_o = active ? data_g : '0;

  // Address decode
  logic                  mapped;
  logic                  slave_ack;
  logic [DATA_W-1:0]     slave_data;
  logic [NUM_SLAVES-1:0] slave_oh;

  always_comb begin
    mapped     = 1'b0;
    slave_ack  = 1'b0;
    slave_data = '0;
    slave_oh   = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (sel == SEL_W'(s)) begin
        mapped      = 1'b1;
        slave_ack   = bus.s_ack_i[s];
        slave_data  = bus.s_data_i[s*DATA_W +: DATA_W];
        slave_oh[s] = 1'b1;
      end
    end
  end

  logic timeout_hit;
  logic pass;   // strobe reaches a real slave this cycle
  logic term;   // interconnect terminates the strobe itself with an error
  logic ack;

  assign pass        = stb && mapped && !timeout_hit;
  assign term        = stb && (timeout_hit || !mapped);
  assign ack         = term || (pass && slave_ack);
  assign bus.s_stb_o = pass ? slave_oh : '0;
  assign bus.m_data_o = pass ? slave_data : '0;
  assign bus.m_ack_o = ack ? gnt_oh : '0;
  assign bus.m_err_o = term ? gnt_oh : '0;

`ifdef VMICRO16_WB_TIMEOUT_EN
  logic [15:0] tcnt;

  assign timeout_hit = (state == OWNED) && (tcnt == 16'(TIMEOUT));

  // Counts consecutive unacknowledged strobe cycles; any gap in the strobe,
  // any ack (including the timeout's own) restarts it.
  always_ff @(posedge clk) begin
    if (reset)
      tcnt <= '0;
    else if (!stb || ack)
      tcnt <= '0;
    else
      tcnt <= tcnt + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Ownership FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      rr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            gnt   <= arb_gnt;
            state <= OWNED;
          end
        end
        OWNED: begin
          if (!cyc_g) begin
            state <= IDLE;
            rr    <= MW'(next_rr(32'(gnt), NUM_MASTERS));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
